// File: rtl/order_scheduler.sv
// Order queue and sequencer: buffers validated orders, issues them one at a
// time to the dispense controllers and guards each order with a watchdog.
module order_scheduler #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  input  logic [15:0]                cmd_data,
  output logic                       cmd_accept,
  output logic                       cmd_reject,
  input  logic [4:0]                 disp_busy,
  output logic                       disp_start,
  output logic [14:0]                disp_cmd,
  output logic                       order_done,
  output logic                       fault,
  input  logic                       clear_fault,
  output logic [$clog2(DEPTH):0]     queue_count,
  output logic                       sched_busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [14:0]   mem_q [DEPTH];
  logic [14:0]   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [14:0]   disp_cmd_q, disp_cmd_d;
  logic          disp_start_q, disp_start_d;
  logic          order_done_q, order_done_d;
  logic          cmd_accept_q, cmd_accept_d;
  logic          cmd_reject_q, cmd_reject_d;
  logic          fault_q, fault_d;
  logic          sched_busy_q, sched_busy_d;
  logic          push, pop;
  logic          busy_any;

  assign busy_any = (disp_busy != 5'd0);

  // Next-state, intake, FIFO and output computation
  always_comb begin
    state_d      = state_q;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    guard_d      = guard_q;
    wdog_d       = wdog_q;
    disp_cmd_d   = disp_cmd_q;
    disp_start_d = 1'b0;
    order_done_d = 1'b0;
    cmd_accept_d = 1'b0;
    cmd_reject_d = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (count_q != CW'(0) && !busy_any) begin
          state_d = ST_ISSUE;
          pop     = 1'b1;
        end
      end
      ST_ISSUE: begin
        wdog_d  = WW'(0);
        guard_d = GW'(0);
        state_d = ST_ARM;
      end
      ST_ARM: begin
        // Dispenser busy flags are not trusted until the start latency elapses
        if (guard_q == GW'(GUARD_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          guard_d = guard_q + GW'(1);
        end
      end
      ST_RUN: begin
        if (!busy_any) begin
          state_d      = ST_DONE;
          order_done_d = 1'b1;
        end else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_FAULT;
        end else if (wdog_q != {WW{1'b1}}) begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (clear_fault && !busy_any) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Head of queue goes out together with the start pulse
    if (pop) begin
      disp_cmd_d   = mem_q[rd_ptr_q];
      disp_start_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + PW'(1);
    end

    // Fullness uses the count before this cycle, so a same-cycle pop never frees space
    if (cmd_valid) begin
      if (!cmd_data[15] || cmd_data[14:0] == 15'd0 ||
          count_q == CW'(DEPTH) || state_q == ST_FAULT) begin
        cmd_reject_d = 1'b1;
      end else begin
        cmd_accept_d       = 1'b1;
        push               = 1'b1;
        mem_d[wr_ptr_q]    = cmd_data[14:0];
        wr_ptr_d           = wr_ptr_q + PW'(1);
      end
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Entering FAULT discards every queued order
    if (state_q != ST_FAULT && state_d == ST_FAULT) begin
      wr_ptr_d = PW'(0);
      rd_ptr_d = PW'(0);
      count_d  = CW'(0);
    end

    fault_d      = (state_d == ST_FAULT);
    sched_busy_d = (state_d != ST_IDLE);
  end

  // State, FIFO and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 15'd0;
      wr_ptr_q     <= PW'(0);
      rd_ptr_q     <= PW'(0);
      count_q      <= CW'(0);
      guard_q      <= GW'(0);
      wdog_q       <= WW'(0);
      disp_cmd_q   <= 15'd0;
      disp_start_q <= 1'b0;
      order_done_q <= 1'b0;
      cmd_accept_q <= 1'b0;
      cmd_reject_q <= 1'b0;
      fault_q      <= 1'b0;
      sched_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      guard_q      <= guard_d;
      wdog_q       <= wdog_d;
      disp_cmd_q   <= disp_cmd_d;
      disp_start_q <= disp_start_d;
      order_done_q <= order_done_d;
      cmd_accept_q <= cmd_accept_d;
      cmd_reject_q <= cmd_reject_d;
      fault_q      <= fault_d;
      sched_busy_q <= sched_busy_d;
    end
  end

  assign cmd_accept  = cmd_accept_q;
  assign cmd_reject  = cmd_reject_q;
  assign disp_start  = disp_start_q;
  assign disp_cmd    = disp_cmd_q;
  assign order_done  = order_done_q;
  assign fault       = fault_q;
  assign queue_count = count_q;
  assign sched_busy  = sched_busy_q;

endmodule

// File: tb/tb_order_scheduler.sv
// Scoreboard bench for order_scheduler: directed scenarios plus random orders,
// checked against an order-lifecycle reference model.
module tb_order_scheduler;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned GUARD   = 4;
  localparam int unsigned TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_accept, cmd_reject;
  logic [4:0]  disp_busy;
  logic        disp_start;
  logic [14:0] disp_cmd;
  logic        order_done;
  logic        fault;
  logic        clear_fault;
  logic [2:0]  queue_count;
  logic        sched_busy;

  order_scheduler #(.DEPTH(DEPTH), .GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .cmd_accept(cmd_accept), .cmd_reject(cmd_reject), .disp_busy(disp_busy),
    .disp_start(disp_start), .disp_cmd(disp_cmd), .order_done(order_done),
    .fault(fault), .clear_fault(clear_fault), .queue_count(queue_count),
    .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Dispenser responder: busy for rsp_len cycles after each start
  logic [4:0] ext_busy;
  logic       model_busy;
  int         rsp_len;
  int         rsp_cnt;
  bit         stuck;
  bit         release_stuck;
  assign disp_busy = ext_busy | {model_busy, 3'b000, model_busy};

  always @(negedge clk) if (rst_n && disp_start) rsp_cnt = stuck ? 1000000 : rsp_len;
  always @(posedge clk) begin
    #1;
    if (!rst_n || release_stuck) rsp_cnt = 0;
    if (rsp_cnt > 0) begin
      model_busy = 1'b1;
      rsp_cnt--;
    end else begin
      model_busy = 1'b0;
    end
  end

  // Reference model state
  typedef struct { int due; bit acc; logic [14:0] d; } exp_t;
  exp_t        exp_q[$];
  logic [14:0] m_q[$];
  logic [14:0] exp_cmd;
  bit nx_free, nx_start, nx_done, nx_fault, prev_fault, in_flight;
  int t0;
  bit pend, pend_nx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, want, cyc);
    end
  endtask

  // Monitor: compares every output each cycle against the model
  always @(negedge clk) begin
    bit cur_free, cur_start, cur_done, cur_fault, busy0;
    exp_t e;
    int age;
    if (!rst_n) begin
      chk("reset_outputs",
          32'({disp_start, cmd_accept, cmd_reject, order_done, fault, sched_busy, disp_cmd, queue_count}),
          32'd0);
      exp_q.delete(); m_q.delete();
      exp_cmd = 15'd0;
      nx_free = 1'b1; nx_start = 1'b0; nx_done = 1'b0; nx_fault = 1'b0;
      prev_fault = 1'b0; in_flight = 1'b0;
    end else begin
      cur_free = nx_free; cur_start = nx_start; cur_done = nx_done; cur_fault = nx_fault;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("intake_response", 32'({cmd_accept, cmd_reject}), e.acc ? 32'd2 : 32'd1);
        if (e.acc) m_q.push_back(e.d);
      end else begin
        chk("intake_quiet", 32'({cmd_accept, cmd_reject}), 32'd0);
      end
      chk("fault", 32'(fault), 32'(cur_fault));
      if (cur_fault && !prev_fault) m_q.delete();
      prev_fault = cur_fault;
      chk("disp_start", 32'(disp_start), 32'(cur_start));
      if (cur_start) begin
        if (m_q.size() > 0) exp_cmd = m_q.pop_front();
        in_flight = 1'b1;
        t0 = cyc;
      end
      chk("disp_cmd", 32'(disp_cmd), 32'(exp_cmd));
      chk("order_done", 32'(order_done), 32'(cur_done));
      chk("sched_busy", 32'(sched_busy), 32'(!cur_free));
      chk("queue_count", 32'(queue_count), 32'(m_q.size()));
      busy0 = (disp_busy == 5'd0);
      nx_done  = 1'b0;
      nx_fault = cur_fault && !(clear_fault && busy0);
      if (in_flight) begin
        age = cyc - t0;
        if (age >= int'(GUARD) + 1 && busy0) begin
          nx_done = 1'b1; in_flight = 1'b0;
        end else if (age == int'(GUARD + TIMEOUT)) begin
          nx_fault = 1'b1; in_flight = 1'b0;
        end
      end
      nx_start = cur_free && m_q.size() > 0 && busy0;
      nx_free  = cur_free ? !nx_start : (cur_done || (cur_fault && clear_fault && busy0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pend = pend_nx;
    pend_nx = 1'b0;
    cmd_valid = 1'b0;
  endtask

  // Drive one order for the current cycle and queue its expected response
  task automatic send(input logic [15:0] d);
    int sz;
    bit acc;
    exp_t e;
    sz  = m_q.size() + int'(pend) - int'(nx_start);
    acc = d[15] && (d[14:0] != 15'd0) && (sz < int'(DEPTH)) && !nx_fault;
    cmd_valid = 1'b1;
    cmd_data  = d;
    e.due = cyc + 1; e.acc = acc; e.d = d[14:0];
    exp_q.push_back(e);
    pend_nx = acc;
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (nx_free && m_q.size() == 0 && !pend && !pend_nx && !nx_fault) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_idle: scheduler not idle within %0d cycles at cycle %0d", limit, cyc);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit hit;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 16'd0; ext_busy = 5'd0;
    clear_fault = 1'b0; rsp_len = 0; stuck = 1'b0; release_stuck = 1'b0;
    rsp_cnt = 0; model_busy = 1'b0; pend = 1'b0; pend_nx = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single order, dispensers busy 10 cycles
    rsp_len = 10;
    send(16'h8049);
    tick();
    wait_idle(200);

    // Invalid orders: GO clear, and GO with empty amounts
    send(16'h0049); tick();
    send(16'h8000); tick();
    repeat (3) tick();
    wait_idle(50);

    // Fill while dispensers busy, overflow, then drain in order
    ext_busy = 5'b00001;
    rsp_len  = 6;
    for (int i = 0; i < 5; i++) begin
      send(16'h8000 | 16'(i + 1) * 16'h0111);
      tick();
    end
    repeat (2) tick();
    ext_busy = 5'd0;
    send(16'h8111);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (nx_free && m_q.size() > 0) begin
        send(16'h8222);
        hit = 1'b1;
        break;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL pop_push_window: no idle slot seen at cycle %0d", cyc);
    end
    tick();
    wait_idle(500);

    // Watchdog fault, rejection while faulted, clear handshake
    stuck = 1'b1;
    send(16'h8123);
    tick();
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (nx_fault) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL fault_wait: model never reached fault at cycle %0d", cyc);
    end
    stuck = 1'b0;
    tick();
    send(16'h8124);
    tick();
    clear_fault = 1'b1;
    repeat (3) tick();
    clear_fault = 1'b0;
    release_stuck = 1'b1;
    repeat (2) tick();
    release_stuck = 1'b0;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    repeat (2) tick();
    rsp_len = 3;
    send(16'h8125);
    tick();
    wait_idle(200);

    // Reset in the middle of a running order
    rsp_len = 30;
    send(16'h0ABC | 16'h8000);
    repeat (14) tick();
    rst_n = 1'b0;
    pend = 1'b0;
    pend_nx = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    rsp_len = 5;
    send(16'h8DEF);
    tick();
    wait_idle(200);

    // Randomized orders and dispenser latencies
    for (int i = 0; i < 400; i++) begin
      rsp_len = int'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) begin
        cmd_data = 16'($urandom);
        if ($urandom_range(0, 7) != 0) cmd_data[15] = 1'b1;
        if ($urandom_range(0, 15) == 0) cmd_data[14:0] = 15'd0;
        send(cmd_data);
      end
      tick();
    end
    wait_idle(500);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
